// File: rtl/rr_arbiter16_if.sv
// rtl/rr_arbiter16_if.sv - request/grant bundle shared by the requesters and the 16-way arbiter
//
// Signals:
//   req        requester -> arbiter  request vector, bit i = requester i
//   release_i  requester -> arbiter  current owner is done with the resource
//   mode       requester -> arbiter  0 = round-robin, 1 = fixed priority (highest index)
//   gnt        arbiter -> requester  one-hot grant
//   gnt_idx    arbiter -> requester  binary index of the granted requester
//   gnt_valid  arbiter -> requester  a grant is active
//   timeout    arbiter -> requester  one-cycle pulse when a grant is forced off
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter16_if #(
    parameter int N    = 16,
    parameter int IDXW = 4
);
    logic [N-1:0]    req;
    logic            release_i;
    logic            mode;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, release_i, mode,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, release_i, mode,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - 16-way round-robin / fixed-priority arbiter with grant hold and hold timeout
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter16_if.slave: req, release_i, mode in; gnt, gnt_idx, gnt_valid, timeout out
// Parameters:
//   N        number of requesters (16 for this revision)
//   IDXW     grant index width, log2(N)
//   MAX_HOLD maximum grant length in cycles; 0 disables the timeout
module rr_arbiter16 #(
    parameter int N        = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter16_if.slave bus
);

    localparam int              CW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [CW-1:0]   hold, hold_n;
    logic [N-1:0]    gnt_q, gnt_n;
    logic [IDXW-1:0] idx_q, idx_n;
    logic            to_q, to_n;

    logic [N-1:0]    below_ptr;
    logic [N-1:0]    rr_masked;
    logic [N-1:0]    rr_src;
    logic [IDXW-1:0] rr_win;
    logic [IDXW-1:0] hp_win;
    logic [IDXW-1:0] win;

    // Round-robin: take the lowest request at or above ptr; if none, the lowest
    // request overall, which is the wrap-around past index N-1.
    always_comb begin
        below_ptr = (N'(1) << ptr) - N'(1);
        rr_masked = bus.req & ~below_ptr;
        rr_src    = (|rr_masked) ? rr_masked : bus.req;
        rr_win    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rr_src[i]) begin
                rr_win = IDXW'(i);
            end
        end
    end

    // Fixed priority: highest set index wins.
    always_comb begin
        hp_win = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                hp_win = IDXW'(i);
            end
        end
    end

    assign win = bus.mode ? hp_win : rr_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            hold  <= '0;
            gnt_q <= '0;
            idx_q <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
            gnt_q <= gnt_n;
            idx_q <= idx_n;
            to_q  <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold;
        gnt_n   = gnt_q;
        idx_n   = idx_q;
        to_n    = 1'b0;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    gnt_n   = N'(1) << win;
                    idx_n   = win;
                    hold_n  = CW'(1);
                    // IDXW bits wrap N-1 back to 0 on their own.
                    ptr_n   = win + IDXW'(1);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // Release outranks the timeout, so a simultaneous release never pulses timeout.
                if (bus.release_i || !bus.req[idx_q]) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end else if ((MAX_HOLD != 0) && (hold == HOLD_LAST)) begin
                    gnt_n   = '0;
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    hold_n  = hold + CW'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb/tb_rr_arbiter16.sv - randomized and directed self-checking bench for rr_arbiter16
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_arbiter16_if #(.N(16), .IDXW(4)) bus ();

    rr_arbiter16 #(.N(16), .IDXW(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: who owns the resource, how long, and where the search starts.
    bit m_busy;
    int m_owner;
    int m_held;
    int m_ptr;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input bit m, input int p);
        if (m) begin
            for (int i = 15; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 16; k++) if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 0;
    endtask

    task automatic model_edge(input logic [15:0] r, input bit rel, input bit m);
        int w;
        m_to = 0;
        if (!m_busy) begin
            w = pick(r, m, m_ptr);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_held  = 1;
                m_ptr   = (w + 1) % 16;
            end
        end else if (rel || !r[m_owner]) begin
            m_busy = 0;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_busy = 0;
            m_to   = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_gnt;
        exp_gnt = m_busy ? (16'h1 << m_owner) : 16'h0;
        check("gnt",       32'(bus.gnt),       32'(exp_gnt));
        check("gnt_idx",   32'(bus.gnt_idx),   32'(m_owner));
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
        check("timeout",   32'(bus.timeout),   32'(m_to));
    endtask

    task automatic step(input logic [15:0] r, input bit rel, input bit m);
        bus.req       = r;
        bus.release_i = rel;
        bus.mode      = m;
        @(posedge clk);
        model_edge(r, rel, m);
        #1;
        compare_all();
    endtask

    task automatic idle_gap();
        step(16'h0, 1'b0, 1'b0);
        step(16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] r;
        bit rel, m;
        int cnt;

        bus.req = '0;
        bus.release_i = 1'b0;
        bus.mode = 1'b0;
        model_reset();

        // Reset and idle
        @(posedge clk);
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(16'h0, 1'b0, 1'b0);

        // Fixed priority: 0x0025 -> idx 5, again after the idle cycle
        step(16'h0025, 1'b0, 1'b1);
        check("fp_gnt", 32'(bus.gnt), 32'h0020);
        step(16'h0025, 1'b1, 1'b1);
        step(16'h0025, 1'b0, 1'b1);
        check("fp_regnt_idx", 32'(bus.gnt_idx), 32'd5);
        step(16'h0025, 1'b1, 1'b1);
        idle_gap();

        // Round-robin between 0 and 15 with release every busy cycle
        for (int i = 0; i < 8; i++) step(16'h8001, 1'b1, 1'b0);
        idle_gap();

        // Timeout: exactly MAX_HOLD cycles of grant, then a timeout pulse, then re-grant
        cnt = 0;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(16'h0010, 1'b0, 1'b0);
            if (bus.gnt == 16'h0010) cnt++;
        end
        check("hold_len", 32'(cnt), 32'(MAX_HOLD));
        step(16'h0010, 1'b0, 1'b0);
        check("to_pulse", 32'(bus.timeout), 32'd1);
        step(16'h0010, 1'b0, 1'b0);
        check("to_regnt", 32'(bus.gnt_idx), 32'd4);
        step(16'h0010, 1'b1, 1'b0);
        idle_gap();

        // Owner drops its request mid-grant
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        check("drop_gnt", 32'(bus.gnt), 32'h0);
        idle_gap();

        // Release on the same edge as the hold limit: no timeout
        step(16'h0010, 1'b0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(16'h0010, 1'b0, 1'b0);
        step(16'h0010, 1'b1, 1'b0);
        check("rel_vs_to", 32'(bus.timeout), 32'd0);
        idle_gap();

        // Async reset mid-grant
        step(16'h0100, 1'b0, 1'b1);
        step(16'h0100, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        step(16'h0101, 1'b0, 1'b0);
        check("post_rst_idx", 32'(bus.gnt_idx), 32'd0);
        step(16'h0101, 1'b1, 1'b0);

        // Randomized traffic; requests stay stable for stretches so timeouts occur
        r = 16'(($urandom & $urandom));
        m = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 16'(($urandom & $urandom));
            if ($urandom_range(0, 15) == 0) r = 16'h0;
            if ($urandom_range(0, 7) == 0) m = 1'($urandom);
            rel = ($urandom_range(0, 4) == 0);
            step(r, rel, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
